// File: rtl/cond_unit.sv
// Execute-stage conditional-execution unit: NZCV flag register, condition evaluation,
// strobe gating and a predicated-block mode with a shared latched condition.
module cond_unit #(
  parameter int unsigned MAX_BLK = 4,
  localparam int unsigned LEN_W = $clog2(MAX_BLK + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             blk_start,
  input  logic [LEN_W-1:0] blk_len,
  input  logic [3:0]       blk_cond,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             cond_ex,
  output logic [3:0]       flags,
  output logic             blk_active,
  output logic [LEN_W-1:0] blk_remaining
);

  typedef enum logic [0:0] {StIdle, StBlock} state_e;

  state_e           state_q;
  logic [3:0]       flags_q;
  logic [3:0]       bcond_q;
  logic [LEN_W-1:0] cnt_q;

  logic             own_ok;
  logic             blk_ok;
  logic [LEN_W-1:0] len_clamp;

  function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic res;
    {n, z, cy, v} = f;
    unique case (c)
      4'd0:    res = z;
      4'd1:    res = ~z;
      4'd2:    res = cy;
      4'd3:    res = ~cy;
      4'd4:    res = n;
      4'd5:    res = ~n;
      4'd6:    res = v;
      4'd7:    res = ~v;
      4'd8:    res = cy & ~z;
      4'd9:    res = ~cy | z;
      4'd10:   res = (n == v);
      4'd11:   res = (n != v);
      4'd12:   res = ~z & (n == v);
      4'd13:   res = z | (n != v);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  // Predicates always look at the registered flags, never at this cycle's ALU result.
  assign own_ok  = eval_cond(cond, flags_q);
  assign blk_ok  = eval_cond(bcond_q, flags_q);
  assign cond_ex = own_ok & ((state_q != StBlock) | blk_ok);

  assign pc_src    = en & pcs & cond_ex;
  assign reg_write = en & reg_w & cond_ex;
  assign mem_write = en & mem_w & cond_ex;

  assign len_clamp = (blk_len > LEN_W'(MAX_BLK)) ? LEN_W'(MAX_BLK) : blk_len;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      flags_q <= '0;
      bcond_q <= '0;
      cnt_q   <= '0;
    end else if (en) begin
      if (cond_ex) begin
        if (flag_w[1]) flags_q[3:2] <= alu_flags[3:2];
        if (flag_w[0]) flags_q[1:0] <= alu_flags[1:0];
      end
      case (state_q)
        StIdle: begin
          if (blk_start && cond_ex && (blk_len != '0)) begin
            state_q <= StBlock;
            cnt_q   <= len_clamp;
            bcond_q <= blk_cond;
          end
        end
        StBlock: begin
          // blk_start is ignored here: blocks do not nest or reload.
          if (pc_src || (cnt_q == LEN_W'(1))) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign flags         = flags_q;
  assign blk_active    = (state_q == StBlock);
  assign blk_remaining = cnt_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_cond_unit;
  localparam int unsigned MAX_BLK = 4;
  localparam int unsigned LEN_W = 3;

  logic             clk = 1'b0;
  logic             reset, en, pcs, reg_w, mem_w, blk_start;
  logic [3:0]       cond, alu_flags, blk_cond;
  logic [1:0]       flag_w;
  logic [LEN_W-1:0] blk_len;
  logic             pc_src, reg_write, mem_write, cond_ex, blk_active;
  logic [3:0]       flags;
  logic [LEN_W-1:0] blk_remaining;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  bit [3:0] m_flags;
  bit       m_active;
  int       m_rem;
  bit [3:0] m_bcond;

  cond_unit #(.MAX_BLK(MAX_BLK)) dut (
    .clk(clk), .reset(reset), .en(en), .cond(cond), .alu_flags(alu_flags),
    .flag_w(flag_w), .pcs(pcs), .reg_w(reg_w), .mem_w(mem_w), .blk_start(blk_start),
    .blk_len(blk_len), .blk_cond(blk_cond), .pc_src(pc_src), .reg_write(reg_write),
    .mem_write(mem_write), .cond_ex(cond_ex), .flags(flags), .blk_active(blk_active),
    .blk_remaining(blk_remaining)
  );

  always #5 clk = ~clk;

  function automatic bit spec_cond(input int c, input bit [3:0] f);
    bit n = f[3];
    bit z = f[2];
    bit cy = f[1];
    bit v = f[0];
    case (c)
      0: return z;
      1: return !z;
      2: return cy;
      3: return !cy;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return cy && !z;
      9: return !cy || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit m_cex();
    bit ok = spec_cond(int'(cond), m_flags);
    if (m_active) ok = ok && spec_cond(int'(m_bcond), m_flags);
    return ok;
  endfunction

  function automatic logic [11:0] m_outputs();
    bit ce = m_cex();
    return {en & pcs & ce, en & reg_w & ce, en & mem_w & ce, ce, m_flags, m_active,
            3'(m_rem)};
  endfunction

  task automatic model_step();
    bit ce;
    if (!reset) begin
      m_flags = '0; m_active = 0; m_rem = 0;
    end else if (en) begin
      ce = m_cex();
      if (ce && flag_w[1]) m_flags[3:2] = alu_flags[3:2];
      if (ce && flag_w[0]) m_flags[1:0] = alu_flags[1:0];
      if (m_active) begin
        if (pcs && ce) begin
          m_active = 0; m_rem = 0;
        end else begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_active = 0;
        end
      end else if (blk_start && ce && blk_len != 0) begin
        m_active = 1;
        m_rem = (int'(blk_len) > MAX_BLK) ? MAX_BLK : int'(blk_len);
        m_bcond = blk_cond;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reset = 1; en = 1; cond = 4'd14; alu_flags = 0; flag_w = 0;
    pcs = 0; reg_w = 0; mem_w = 0; blk_start = 0; blk_len = 0; blk_cond = 0;
  endtask

  task automatic test_reset();
    set_idle();
    reset = 0; en = 0;
    cond = 4'($urandom); alu_flags = 4'($urandom); flag_w = 2'($urandom);
    pcs = 1; reg_w = 1; mem_w = 1; blk_start = 1; blk_len = 3'($urandom);
    tick(); tick();
    n_tests++;
    if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags); end
    n_tests++;
    if (blk_active !== 1'b0 || blk_remaining !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_blk: got active=%b rem=%0d want 0/0", blk_active, blk_remaining);
    end
    n_tests++;
    if ({pc_src, reg_write, mem_write} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000", {pc_src, reg_write, mem_write});
    end
    set_idle();
  endtask

  task automatic test_flags();
    set_idle();
    cond = 14; reg_w = 1; flag_w = 2'b11; alu_flags = 4'b0100;
    #1;
    n_tests++;
    if (reg_write !== 1'b1) begin n_fail++; $display("FAIL al_reg_write: got %b want 1", reg_write); end
    tick();
    n_tests++;
    if (flags !== 4'b0100) begin n_fail++; $display("FAIL flag_update: got %b want 0100", flags); end
    flag_w = 0; alu_flags = 0; cond = 0;
    #1;
    n_tests++;
    if (reg_write !== 1'b1) begin n_fail++; $display("FAIL eq_taken: got %b want 1", reg_write); end
    cond = 1;
    #1;
    n_tests++;
    if (reg_write !== 1'b0) begin n_fail++; $display("FAIL ne_squash: got %b want 0", reg_write); end
    set_idle();
  endtask

  task automatic test_split();
    set_idle();
    reset = 0; tick(); reset = 1;
    flag_w = 2'b01; alu_flags = 4'b1111; cond = 14;
    tick();
    n_tests++;
    if (flags !== 4'b0011) begin n_fail++; $display("FAIL split_cv: got %b want 0011", flags); end
    flag_w = 0; cond = 8;
    #1;
    n_tests++;
    if (cond_ex !== 1'b1) begin n_fail++; $display("FAIL hi_true: got %b want 1", cond_ex); end
    cond = 10;
    #1;
    n_tests++;
    if (cond_ex !== 1'b0) begin n_fail++; $display("FAIL ge_false: got %b want 0", cond_ex); end
    set_idle();
  endtask

  task automatic test_squash();
    set_idle();
    cond = 0; flag_w = 2'b11; mem_w = 1; alu_flags = 4'b1000;
    #1;
    n_tests++;
    if (mem_write !== 1'b0) begin n_fail++; $display("FAIL squash_mem: got %b want 0", mem_write); end
    tick();
    n_tests++;
    if (flags !== 4'b0011) begin n_fail++; $display("FAIL squash_flags: got %b want 0011", flags); end
    set_idle();
  endtask

  task automatic test_block();
    set_idle();
    flag_w = 2'b10; alu_flags = 4'b0100;
    tick();
    n_tests++;
    if (flags !== 4'b0111) begin n_fail++; $display("FAIL set_z: got %b want 0111", flags); end
    flag_w = 0; blk_start = 1; blk_len = 3; blk_cond = 0;
    tick();
    n_tests++;
    if (blk_active !== 1'b1 || blk_remaining !== 3'd3) begin
      n_fail++; $display("FAIL blk_open: got active=%b rem=%0d want 1/3", blk_active, blk_remaining);
    end
    blk_start = 0; reg_w = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (reg_write !== 1'b1) begin n_fail++; $display("FAIL blk_reg_w%0d: got %b want 1", i, reg_write); end
      tick();
      n_tests++;
      if (blk_remaining !== 3'(2 - i)) begin
        n_fail++; $display("FAIL blk_rem%0d: got %0d want %0d", i, blk_remaining, 2 - i);
      end
    end
    n_tests++;
    if (blk_active !== 1'b0) begin n_fail++; $display("FAIL blk_close: got %b want 0", blk_active); end
    set_idle();
  endtask

  task automatic test_block_boundaries();
    set_idle();
    blk_start = 1; blk_len = 7; blk_cond = 0;
    tick();
    n_tests++;
    if (blk_remaining !== 3'd4) begin n_fail++; $display("FAIL blk_clamp: got %0d want 4", blk_remaining); end
    blk_start = 0; en = 0; reg_w = 1;
    #1;
    n_tests++;
    if (reg_write !== 1'b0) begin n_fail++; $display("FAIL stall_strobe: got %b want 0", reg_write); end
    tick(); tick();
    n_tests++;
    if (blk_active !== 1'b1 || blk_remaining !== 3'd4) begin
      n_fail++; $display("FAIL stall_hold: got active=%b rem=%0d want 1/4", blk_active, blk_remaining);
    end
    en = 1;
    tick();
    n_tests++;
    if (blk_remaining !== 3'd3) begin n_fail++; $display("FAIL stall_resume: got %0d want 3", blk_remaining); end
    blk_start = 1; blk_len = 3;
    tick();
    n_tests++;
    if (blk_active !== 1'b1 || blk_remaining !== 3'd2) begin
      n_fail++; $display("FAIL nested: got active=%b rem=%0d want 1/2", blk_active, blk_remaining);
    end
    blk_start = 0; reg_w = 0; pcs = 1;
    #1;
    n_tests++;
    if (pc_src !== 1'b1) begin n_fail++; $display("FAIL blk_branch: got %b want 1", pc_src); end
    tick();
    n_tests++;
    if (blk_active !== 1'b0 || blk_remaining !== 3'd0) begin
      n_fail++; $display("FAIL branch_exit: got active=%b rem=%0d want 0/0", blk_active, blk_remaining);
    end
    pcs = 0; blk_start = 1; blk_len = 2;
    tick();
    blk_start = 0; reset = 0;
    tick();
    n_tests++;
    if (blk_active !== 1'b0 || blk_remaining !== 3'd0 || flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid: got active=%b rem=%0d flags=%b want 0/0/0000", blk_active,
               blk_remaining, flags);
    end
    set_idle();
  endtask

  task automatic test_random();
    logic [11:0] got, want;
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 39) != 0);
      en = ($urandom_range(0, 3) != 0);
      cond = 4'($urandom); alu_flags = 4'($urandom); flag_w = 2'($urandom);
      pcs = ($urandom_range(0, 5) == 0);
      reg_w = 1'($urandom); mem_w = 1'($urandom);
      blk_start = ($urandom_range(0, 3) == 0);
      blk_len = 3'($urandom); blk_cond = 4'($urandom);
      #1;
      got = {pc_src, reg_write, mem_write, cond_ex, flags, blk_active, blk_remaining};
      want = m_outputs();
      n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL random%0d {pc,rw,mw,cex,nzcv,act,rem}: got %b want %b", i, got, want);
      end
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_flags();
    test_split();
    test_squash();
    test_block();
    test_block_boundaries();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution unit for the execute stage; successor to the single-zero-flag write-gating logic.
- Holds a full NZCV flag register with split update enables and evaluates a 4-bit condition code against it.
- Gates the branch, register-write and memory-write strobes.
- Adds predicated-block mode: one instruction arms a shared condition that also qualifies the next 1..MAX_BLK instructions.

Parameters:
MAX_BLK, 4, maximum predicated-block length in instructions (>=1)
LEN_W, $clog2(MAX_BLK+1), width of block length/counter (derived, not overridden)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-low reset (sampled on rising edge of clk; 0 = reset)
en  input  1  pipeline advance; 0 = stall, no state change, all strobes forced 0
cond  input  4  condition code of current instruction
alu_flags  input  4  {N,Z,C,V} produced by ALU for current instruction
flag_w  input  2  [1] = update N,Z; [0] = update C,V
pcs  input  1  instruction requests PC write (branch)
reg_w  input  1  instruction requests register write
mem_w  input  1  instruction requests memory write
blk_start  input  1  current instruction opens a predicated block
blk_len  input  LEN_W  block length (instructions following this one)
blk_cond  input  4  shared condition for the block
pc_src  output  1  gated branch strobe
reg_write  output  1  gated register write
mem_write  output  1  gated memory write
cond_ex  output  1  effective execute predicate of current instruction
flags  output  4  registered {N,Z,C,V}
blk_active  output  1  unit is in BLOCK state
blk_remaining  output  LEN_W  instructions left in block, 0 in IDLE

Behaviour:
- Reset (reset==0 at posedge): flags=0, state=IDLE, counter=0. Combinationally after reset: blk_active=0, blk_remaining=0.
- Condition eval E(c, flags), always on registered flags, never on alu_flags:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14, 15 always true
- cond_ex = E(cond) in IDLE; E(cond) & E(blk_latched_cond) in BLOCK. Combinational, zero latency.
- Strobes: pc_src = en&pcs&cond_ex; reg_write = en&reg_w&cond_ex; mem_write = en&mem_w&cond_ex.
- Flag update at posedge when en&cond_ex:
  - flag_w[1]: N,Z <= alu_flags[3:2]
  - flag_w[0]: C,V <= alu_flags[1:0]
  - New flags are visible from the next cycle.
  - Squashed instructions never update flags.
- FSM IDLE -> BLOCK: en & blk_start & cond_ex & blk_len!=0.
  - Latch blk_cond; counter <= min(blk_len, MAX_BLK).
  - blk_len==0 or squashed blk_start: stay IDLE.
- In BLOCK, each en cycle consumes one instruction and decrements counter. Counter 1->0 returns to IDLE at that edge.
- blk_start while in BLOCK: ignored (no reload, no nesting); the instruction itself is still gated by cond_ex.
- Taken branch in BLOCK (pc_src==1): counter<=0, state<=IDLE at that edge.
- en==0: counter, state and flags hold; strobes 0; cond_ex still reflects inputs.
- Reset asserted mid-block overrides all other events in that cycle.

Test Plan:
- Reset: reset=0 for 2 cycles, any inputs -> flags=4'b0000, blk_active=0, blk_remaining=0, all strobes 0.
- Flags:
  - cond=14, reg_w=1, flag_w=2'b11, alu_flags=4'b0100 -> reg_write=1; next cycle flags=4'b0100.
  - Then cond=0 reg_w=1 -> reg_write=1; cond=1 -> reg_write=0.
- Split enables: flags=4'b0000; flag_w=2'b01, alu_flags=4'b1111, cond=14 -> flags=4'b0011 (N,Z untouched). Then cond=8 (HI) -> cond_ex=1; cond=10 (GE) with N=0,V=1 -> 0.
- Squash: flags Z=0, cond=0, flag_w=2'b11, mem_w=1, alu_flags=4'b1000 -> mem_write=0; flags unchanged next cycle.
- Block:
  - Z=1; blk_start, cond=14, blk_len=3, blk_cond=0 -> blk_active=1, blk_remaining=3.
  - Three instructions (cond=14) give reg_write=1 each; remaining 2,1,0; IDLE after the third.
  - Repeat with blk_len=7 (MAX_BLK=4) -> blk_remaining=4.
- Block boundaries:
  - Stall with en=0 for 2 cycles mid-block -> remaining holds.
  - Taken pcs in block -> pc_src=1; next cycle blk_active=0.
  - Nested blk_start mid-block -> remaining decrements normally, no reload.
  - reset=0 mid-block -> IDLE, flags 0.
